// File: rtl/pacman_scan_display.sv
// Pac-Man game for a multiplexed 7-segment board.
// Owns Pac-Man position, facing direction, the eaten mask and level count.
// Scans the digits and drives registered active-low anodes and cathodes.
//
// state  | meaning
// PLAY   | Pac-Man moves one digit per step tick and eats cheese
// DONE   | level cleared, board frozen for HOLD_STEPS step ticks
// REFILL | one cycle: all cheese except under Pac-Man is restored
module pacman_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int STEP_DIV   = 50_000_000,
  parameter int WRAP       = 1,
  parameter int HOLD_STEPS = 3,
  localparam int PW = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir_in,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            cathodes,
  output logic [PW-1:0]         pos,
  output logic [NUM_DIGITS-1:0] eaten_mask,
  output logic                  level_done,
  output logic [7:0]            levels
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_STEPS + 1);

  localparam logic [7:0] PAC_R  = 8'b01100011;
  localparam logic [7:0] PAC_L  = 8'b00001111;
  localparam logic [7:0] CHEESE = 8'b11111101;
  localparam logic [7:0] OFF    = 8'hFF;

  typedef enum logic [1:0] {S_PLAY, S_DONE, S_REFILL} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [TW-1:0]         step_cnt_q, step_cnt_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [NUM_DIGITS-1:0] eaten_q, eaten_d;
  logic [7:0]            levels_q, levels_d;
  logic                  level_done_q, level_done_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]            cathodes_q, cathodes_d;

  logic                  scan_tick;
  logic                  step_tick;
  logic [PW-1:0]         pos_next;
  logic [NUM_DIGITS-1:0] mask_next;
  logic [HW-1:0]         hold_inc;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [PW-1:0] p);
    logic [NUM_DIGITS-1:0] oh;
    for (int i = 0; i < NUM_DIGITS; i++) oh[i] = (p == PW'(i));
    return oh;
  endfunction

  // Scan and step timers; the step timer simply holds while en is low
  always_comb begin
    scan_tick  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_tick) idx_d = (idx_q == PW'(NUM_DIGITS - 1)) ? '0 : idx_q + PW'(1);

    step_tick  = en && (step_cnt_q == TW'(STEP_DIV - 1));
    step_cnt_d = step_cnt_q;
    if (en) step_cnt_d = step_tick ? '0 : step_cnt_q + TW'(1);
  end

  // Candidate position for this tick, using the freshly sampled direction
  always_comb begin
    pos_next = pos_q;
    if (!dir_in) begin
      if (pos_q == PW'(NUM_DIGITS - 1)) pos_next = (WRAP != 0) ? '0 : pos_q;
      else                              pos_next = pos_q + PW'(1);
    end else begin
      if (pos_q == '0) pos_next = (WRAP != 0) ? PW'(NUM_DIGITS - 1) : pos_q;
      else             pos_next = pos_q - PW'(1);
    end
    mask_next = eaten_q | onehot(pos_next);
    hold_inc  = hold_q + HW'(1);
  end

  // Game FSM: movement, eating, level completion and refill
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    eaten_d      = eaten_q;
    levels_d     = levels_q;
    hold_d       = hold_q;
    level_done_d = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (step_tick) begin
          dir_d   = dir_in;
          pos_d   = pos_next;
          eaten_d = mask_next;
          if (&mask_next) begin
            level_done_d = 1'b1;
            levels_d     = levels_q + 8'd1;
            hold_d       = '0;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (step_tick) begin
          hold_d = hold_inc;
          if (hold_inc == HW'(HOLD_STEPS)) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        eaten_d = onehot(pos_q);
        state_d = S_PLAY;
      end
      default: state_d = S_PLAY;
    endcase
  end

  // Display registers follow the current scan index one cycle later
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) anodes_d[i] = (idx_q != PW'(i));
    if (idx_q == pos_q)      cathodes_d = dir_q ? PAC_L : PAC_R;
    else if (eaten_q[idx_q]) cathodes_d = OFF;
    else                     cathodes_d = CHEESE;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PLAY;
      scan_cnt_q   <= '0;
      step_cnt_q   <= '0;
      idx_q        <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      eaten_q      <= NUM_DIGITS'(1);
      levels_q     <= '0;
      level_done_q <= 1'b0;
      hold_q       <= '0;
      anodes_q     <= '1;
      cathodes_q   <= OFF;
    end else begin
      state_q      <= state_d;
      scan_cnt_q   <= scan_cnt_d;
      step_cnt_q   <= step_cnt_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      eaten_q      <= eaten_d;
      levels_q     <= levels_d;
      level_done_q <= level_done_d;
      hold_q       <= hold_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
    end
  end

  assign anodes     = anodes_q;
  assign cathodes   = cathodes_q;
  assign pos        = pos_q;
  assign eaten_mask = eaten_q;
  assign level_done = level_done_q;
  assign levels     = levels_q;

endmodule

// File: tb/tb_pacman_scan_display.sv
// Directed bench: one wrapping and one edge-holding instance.
module tb_pacman_scan_display;

  localparam logic [7:0] PAC_R  = 8'b01100011;
  localparam logic [7:0] PAC_L  = 8'b00001111;
  localparam logic [7:0] CHEESE = 8'b11111101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_w, en_w, dir_w;
  logic [3:0] an_w, em_w;
  logic [7:0] cat_w, lv_w;
  logic [1:0] pos_w;
  logic       ld_w;

  logic       rst_h, en_h, dir_h;
  logic [3:0] an_h, em_h;
  logic [7:0] cat_h, lv_h;
  logic [1:0] pos_h;
  logic       ld_h;

  pacman_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(2), .STEP_DIV(4), .WRAP(1), .HOLD_STEPS(2)) dut_w (
    .clk(clk), .rst(rst_w), .en(en_w), .dir_in(dir_w),
    .anodes(an_w), .cathodes(cat_w), .pos(pos_w),
    .eaten_mask(em_w), .level_done(ld_w), .levels(lv_w));

  pacman_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(2), .STEP_DIV(4), .WRAP(0), .HOLD_STEPS(2)) dut_h (
    .clk(clk), .rst(rst_h), .en(en_h), .dir_in(dir_h),
    .anodes(an_h), .cathodes(cat_h), .pos(pos_h),
    .eaten_mask(em_h), .level_done(ld_h), .levels(lv_h));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [7:0] cath;
  } scan_vec_t;

  scan_vec_t sv[8];

  initial begin
    int   found;
    int   changes;
    int   ld_cnt;
    logic [3:0] prev;

    sv[0] = '{4'b1110, PAC_R};
    sv[1] = '{4'b1110, PAC_R};
    sv[2] = '{4'b1101, CHEESE};
    sv[3] = '{4'b1101, CHEESE};
    sv[4] = '{4'b1011, CHEESE};
    sv[5] = '{4'b1011, CHEESE};
    sv[6] = '{4'b0111, CHEESE};
    sv[7] = '{4'b0111, CHEESE};

    rst_w = 1'b1; en_w = 1'b0; dir_w = 1'b0;
    rst_h = 1'b1; en_h = 1'b0; dir_h = 1'b0;
    cyc_n(2);
    check("rst_anodes",   32'(an_w),  32'hF);
    check("rst_cathodes", 32'(cat_w), 32'hFF);
    check("rst_pos",      32'(pos_w), 32'd0);
    check("rst_mask",     32'(em_w),  32'h1);
    check("rst_levels",   32'(lv_w),  32'd0);
    check("rst_ld",       32'(ld_w),  32'd0);
    check("rst_h_anodes", 32'(an_h),  32'hF);
    check("rst_h_cath",   32'(cat_h), 32'hFF);

    // Scan with en low: table of anode/cathode pairs per cycle
    rst_w = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc_n(1);
      check($sformatf("scan_an_%0d", k),   32'(an_w),  32'(sv[(k-1)%8].an));
      check($sformatf("scan_cat_%0d", k),  32'(cat_w), 32'(sv[(k-1)%8].cath));
      check($sformatf("scan_pos_%0d", k),  32'(pos_w), 32'd0);
    end

    // Right moves through a full level, hold, refill, then wrap
    en_w = 1'b1; dir_w = 1'b0;
    cyc_n(3);
    check("pre_tick_pos", 32'(pos_w), 32'd0);
    cyc_n(1);
    check("tick1_pos",  32'(pos_w), 32'd1);
    check("tick1_mask", 32'(em_w),  32'h3);
    cyc_n(4);
    check("tick2_pos",  32'(pos_w), 32'd2);
    check("tick2_mask", 32'(em_w),  32'h7);
    cyc_n(3);
    check("pre_done_ld", 32'(ld_w), 32'd0);
    cyc_n(1);
    check("tick3_pos",    32'(pos_w), 32'd3);
    check("tick3_mask",   32'(em_w),  32'hF);
    check("tick3_ld",     32'(ld_w),  32'd1);
    check("tick3_levels", 32'(lv_w),  32'd1);
    cyc_n(1);
    check("ld_one_cycle", 32'(ld_w), 32'd0);
    cyc_n(3);
    check("hold1_pos",  32'(pos_w), 32'd3);
    check("hold1_mask", 32'(em_w),  32'hF);
    cyc_n(4);
    check("hold2_mask", 32'(em_w), 32'hF);
    cyc_n(1);
    check("refill_mask", 32'(em_w),  32'h8);
    check("refill_pos",  32'(pos_w), 32'd3);
    check("refill_lvls", 32'(lv_w),  32'd1);
    cyc_n(3);
    check("wrap_r_pos",  32'(pos_w), 32'd0);
    check("wrap_r_mask", 32'(em_w),  32'h9);
    en_w = 1'b0;

    // Left wrap from digit 0
    rst_w = 1'b1; cyc_n(1); rst_w = 1'b0;
    en_w = 1'b1; dir_w = 1'b1;
    cyc_n(4);
    en_w = 1'b0;
    check("wrap_l_pos",  32'(pos_w), 32'd3);
    check("wrap_l_mask", 32'(em_w),  32'h9);
    cyc_n(1);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      cyc_n(1);
      if (an_w == 4'b0111) begin
        found = 1;
        check("wrap_l_glyph", 32'(cat_w), 32'(PAC_L));
      end
    end
    check("wrap_l_digit3_seen", 32'(found), 32'd1);

    // Pause the step timer at step_cnt=2; scan keeps running
    rst_w = 1'b1; cyc_n(1); rst_w = 1'b0;
    en_w = 1'b1; dir_w = 1'b0;
    cyc_n(2);
    en_w = 1'b0;
    changes = 0;
    prev = an_w;
    for (int k = 0; k < 10; k++) begin
      cyc_n(1);
      if (an_w != prev) changes++;
      prev = an_w;
    end
    check("pause_pos",          32'(pos_w), 32'd0);
    check("pause_scan_changes", 32'(changes), 32'd5);
    en_w = 1'b1;
    cyc_n(1);
    check("resume_pos_c1", 32'(pos_w), 32'd0);
    cyc_n(1);
    check("resume_pos_c2", 32'(pos_w), 32'd1);

    // Reset while in DONE
    rst_w = 1'b1; cyc_n(1); rst_w = 1'b0;
    en_w = 1'b1; dir_w = 1'b0;
    cyc_n(12);
    check("done_levels", 32'(lv_w), 32'd1);
    check("done_ld",     32'(ld_w), 32'd1);
    rst_w = 1'b1;
    cyc_n(1);
    check("mid_rst_pos",    32'(pos_w), 32'd0);
    check("mid_rst_mask",   32'(em_w),  32'h1);
    check("mid_rst_levels", 32'(lv_w),  32'd0);
    check("mid_rst_ld",     32'(ld_w),  32'd0);
    check("mid_rst_an",     32'(an_w),  32'hF);
    check("mid_rst_cat",    32'(cat_w), 32'hFF);
    rst_w = 1'b0;
    cyc_n(4);
    check("mid_rst_play", 32'(pos_w), 32'd1);
    en_w = 1'b0;

    // Edge-holding instance: clear a level, then push against the right edge
    rst_h = 1'b0; en_h = 1'b1; dir_h = 1'b0;
    cyc_n(12);
    check("hold_inst_pos",    32'(pos_h), 32'd3);
    check("hold_inst_levels", 32'(lv_h),  32'd1);
    cyc_n(8);
    cyc_n(1);
    check("hold_inst_refill", 32'(em_h), 32'h8);
    ld_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc_n(1);
      if (ld_h) ld_cnt++;
    end
    check("edge_pos",    32'(pos_h),  32'd3);
    check("edge_mask",   32'(em_h),   32'h8);
    check("edge_no_ld",  32'(ld_cnt), 32'd0);
    check("edge_levels", 32'(lv_h),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
